// File: rtl/key_schedule_seq128_if.sv
// Round-key expander bus: start/key request, status flags, and indexed round-key read.
// Latency: not applicable (signal bundle only).
// Backpressure: none; the decryptor waits for keys_valid before reading.
//
// Ports (by modport):
//   master (decryptor side): drives start, Key, rd_idx; observes busy, done, keys_valid, rd_key
//   slave  (expander side) : observes start, Key, rd_idx; drives busy, done, keys_valid, rd_key
interface key_schedule_seq128_if;
  logic           start;
  logic [0:127]   Key;
  logic           busy;
  logic           done;
  logic           keys_valid;
  logic [3:0]     rd_idx;
  logic [0:127]   rd_key;

  modport master (
    output start, Key, rd_idx,
    input  busy, done, keys_valid, rd_key
  );

  modport slave (
    input  start, Key, rd_idx,
    output busy, done, keys_valid, rd_key
  );
endinterface

// File: rtl/key_schedule_seq128.sv
// Iterative AES-128 key expander: one round key per clock into an 11-entry register file.
// Latency: done pulses 10 cycles after the accepted start edge; reads are combinational.
// Backpressure: start is ignored while busy; the reader holds off until keys_valid is high.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - key_schedule_seq128_if.slave: start, Key[0:127] in; busy, done, keys_valid out;
//          rd_idx[3:0] in, rd_key[0:127] out (round key rd_idx, zero unless valid and idx<=10)
module key_schedule_seq128 (
  input  logic                   clk,
  input  logic                   rst,
  key_schedule_seq128_if.slave   bus
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_EXPAND = 1'b1;
  localparam logic [3:0] LAST_RND  = 4'd10;
  localparam int         NUM_RK    = 11;

  // Forward S-box, one 16-entry row per high nibble; leftmost byte is low nibble 0.
  localparam logic [127:0] SBOX_ROW [0:15] = '{
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
    logic [127:0] row;
    logic [6:0]   sh;
    row = SBOX_ROW[b[7:4]];
    // Low nibble 0 is the most significant byte of the row.
    sh  = {4'd15 - b[3:0], 3'd0};
    return row[sh +: 8];
  endfunction

  function automatic logic [7:0] rcon_sel(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // One AES-128 schedule step. Words are big-endian in an ascending vector:
  // w0 = [0:31], and byte 0 of each word is its leftmost 8 bits.
  function automatic logic [0:127] expand_step(input logic [0:127] prev, input logic [7:0] rc);
    logic [0:31] t;
    logic [0:31] n0;
    logic [0:31] n1;
    logic [0:31] n2;
    logic [0:31] n3;
    // RotWord(w3) = bytes 13,14,15,12 of the key, then SubWord on each byte.
    t  = {sbox_fwd(prev[104:111]), sbox_fwd(prev[112:119]),
          sbox_fwd(prev[120:127]), sbox_fwd(prev[96:103])} ^ {rc, 24'h0};
    n0 = prev[0:31]   ^ t;
    n1 = prev[32:63]  ^ n0;
    n2 = prev[64:95]  ^ n1;
    n3 = prev[96:127] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  logic [0:0]   state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [0:127] cur_q, cur_d;
  logic         done_q, done_d;
  logic         keys_valid_q, keys_valid_d;
  logic [0:127] rk_q [0:NUM_RK-1];
  logic [0:127] rk_d [0:NUM_RK-1];

  logic         wr_en;
  logic [3:0]   wr_idx;
  logic [0:127] wr_dat;
  logic [0:127] step_dat;
  logic [0:127] rd_key_w;

  // The step always works from cur_q (last written key), so no indexed read of
  // the register file sits on the expansion path.
  always_comb begin
    state_d      = state_q;
    rnd_d        = rnd_q;
    cur_d        = cur_q;
    done_d       = done_q;
    keys_valid_d = keys_valid_q;
    wr_en        = 1'b0;
    wr_idx       = 4'd0;
    wr_dat       = cur_q;
    step_dat     = expand_step(cur_q, rcon_sel(rnd_q));

    case (state_q)
      ST_IDLE: begin
        done_d = 1'b0;
        if (bus.start) begin
          wr_en        = 1'b1;
          wr_idx       = 4'd0;
          wr_dat       = bus.Key;
          cur_d        = bus.Key;
          rnd_d        = 4'd1;
          keys_valid_d = 1'b0;
          state_d      = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        wr_en  = 1'b1;
        wr_idx = rnd_q;
        wr_dat = step_dat;
        cur_d  = step_dat;
        rnd_d  = rnd_q + 4'd1;
        done_d = 1'b0;
        if (rnd_q == LAST_RND) begin
          state_d      = ST_IDLE;
          done_d       = 1'b1;
          keys_valid_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset blocks register-file writes so a start coinciding with rst leaves no trace.
  always_comb begin
    for (int i = 0; i < NUM_RK; i++) begin
      rk_d[i] = (wr_en && !rst && (wr_idx == 4'(i))) ? wr_dat : rk_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rnd_q        <= 4'd0;
      cur_q        <= '0;
      done_q       <= 1'b0;
      keys_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rnd_q        <= rnd_d;
      cur_q        <= cur_d;
      done_q       <= done_d;
      keys_valid_q <= keys_valid_d;
    end
  end

  // Round-key storage is not reset; the read port masks it until keys_valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_RK; i++) begin
      rk_q[i] <= rk_d[i];
    end
  end

  always_comb begin
    rd_key_w = '0;
    if (keys_valid_q) begin
      for (int i = 0; i < NUM_RK; i++) begin
        if (bus.rd_idx == 4'(i)) begin
          rd_key_w = rk_q[i];
        end
      end
    end
  end

  assign bus.busy       = (state_q == ST_EXPAND);
  assign bus.done       = done_q;
  assign bus.keys_valid = keys_valid_q;
  assign bus.rd_key     = rd_key_w;

endmodule
